// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with a single output register.
// Arbitration is either a fixed channel select or round-robin.
module stream_mux_rr #(
   parameter int  WIDTH  = 8,
   parameter int  NUM_CH = 4,
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [SEL_W-1:0]  ch_q, ch_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;

   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  gnt_idx;
   logic [WIDTH-1:0]  gnt_data;
   logic              load_en;
   logic              accept;

   // First valid channel after p, wrapping around; p itself is searched last.
   function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] v,
                                                 input logic [SEL_W-1:0]  p);
      logic [NUM_CH-1:0] g;
      logic              found;
      int                pos;
      g     = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         pos = int'(p) + k;
         if (pos >= NUM_CH) pos = pos - NUM_CH;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && (i == pos) && v[i]) begin
               g[i]  = 1'b1;
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

   always_comb begin
      grant = '0;
      if (!mode) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) grant[i] = in_valid[i];
         end
      end else begin
         grant = rr_pick(in_valid, ptr_q);
      end
   end

   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            gnt_idx  = SEL_W'(i);
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // in_ready is held low while reset is asserted even though the state reads EMPTY.
   assign load_en  = (state_q == EMPTY) | out_ready;
   assign in_ready = grant & {NUM_CH{load_en & rst_n}};
   assign accept   = |in_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = FULL;
         data_d  = gnt_data;
         ch_d    = gnt_idx;
         ptr_d   = gnt_idx;
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= SEL_W'(NUM_CH - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = (state_q == FULL);

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, payload width per channel in bits (1..64).
REQ-002 Parameter NUM_CH, default 4, number of input channels (2..16).
REQ-003 Derived constant SEL_W = max(1, ceil(log2(NUM_CH))), channel index width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_CH*WIDTH  channel payloads, channel i in bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_CH  per-channel valid.
REQ-008 in_ready  output  NUM_CH  per-channel ready.
REQ-009 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel selector, used only in mode 0.
REQ-011 out_data  output  WIDTH  registered output payload.
REQ-012 out_ch  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 A handshake on any port completes in a cycle where valid and ready are both 1 at the rising edge.
REQ-016 The block SHALL hold a single output register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load_en = (state==EMPTY) | out_ready; in_ready[i] = load_en & grant[i]; at most one in_ready bit is 1 in any cycle.
REQ-018 Mode 0: grant[sel] = in_valid[sel] when sel < NUM_CH; all other grant bits are 0; sel >= NUM_CH grants nothing.
REQ-019 Mode 1: grant goes to the first valid channel searching from (ptr+1) mod NUM_CH upward with wrap-around; ptr is the last accepted channel.
REQ-020 grant, in_ready, and the candidate channel SHALL be combinational from current inputs and ptr; in_ready SHALL NOT depend on in_valid of a non-granted channel except through grant.
REQ-021 On input acceptance: out_data <= granted payload, out_ch <= granted index, state -> FULL, ptr <= granted index (both modes).
REQ-022 Latency SHALL be exactly one cycle from input acceptance to out_valid=1 carrying that beat.
REQ-023 Output drained (out_ready=1) with no acceptance in the same cycle: state -> EMPTY; out_data and out_ch hold their last value.
REQ-024 Simultaneous drain and acceptance: the new beat replaces the old one with no bubble; full throughput is one beat per cycle.
REQ-025 FULL with out_ready=0: out_data, out_ch, out_valid SHALL stay stable and all in_ready SHALL be 0.
REQ-026 A mode or sel change takes effect in the same cycle's grant; ptr is retained across mode changes; a beat already in the output register is unaffected.
REQ-027 With no valid granted channel, nothing is accepted and ptr is unchanged.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_data=0, out_ch=0, state=EMPTY, and ptr=NUM_CH-1, so channel 0 has first round-robin priority.
REQ-029 in_ready SHALL be all 0 while rst_n is low.
REQ-030 Reset assertion mid-transfer SHALL discard the held beat; after release the first grant follows REQ-019 from ptr=NUM_CH-1.

Verification
REQ-031 Fixed select: mode=0, sel=2, all valid, ch2=0xA5, out_ready=1 -> in_ready=4'b0100, next cycle out_data=0xA5, out_ch=2, out_valid=1.
REQ-032 Round-robin fairness: mode=1, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-033 Backpressure: FULL with 0x3C, out_ready=0 for 5 cycles -> out_data=0x3C stable, in_ready=0; out_ready=1 -> drained, next beat loaded in that same cycle.
REQ-034 Skip and wrap: mode=1, ptr=1, only ch0 and ch3 valid -> ch3 granted first, then ch0.
REQ-035 Out-of-range and mode switch: mode=0, sel=3 with NUM_CH=3 -> no in_ready; switching to mode=1 -> grant resumes from the retained ptr.
REQ-036 Reset mid-operation: rst_n low while FULL -> out_valid=0 asynchronously; after release with all valid, first out_ch=0.
